// File: rtl/ppp_mbank_buf_if.sv
// ISP write port and DLA read port bundle for the multi-bank ping-pong buffer.
// The buffer itself takes the slave side; the ISP/DLA environment takes the master side.
interface ppp_mbank_buf_if #(
  parameter int NUM_BANK   = 2,
  parameter int PIX_NUM    = 32,
  parameter int CH_IN      = 3,
  parameter int CH_OUT     = 4,
  parameter int ADDR_WIDTH = 10
);
  localparam int ISP_DATA_WIDTH = CH_IN * PIX_NUM * 8;
  localparam int DLA_DATA_WIDTH = CH_OUT * PIX_NUM * 8;
  localparam int BANK_W         = $clog2(NUM_BANK);

  logic                      top_start_i;
  logic                      pad_mode_i;
  logic                      isp_rdy_o;
  logic                      isp_wen_i;
  logic [ADDR_WIDTH-1:0]     isp_waddr_i;
  logic [ISP_DATA_WIDTH-1:0] isp_wdata_i;
  logic                      isp_done_i;
  logic                      dla_rdy_o;
  logic                      dla_ren_i;
  logic [ADDR_WIDTH-1:0]     dla_raddr_i;
  logic [DLA_DATA_WIDTH-1:0] dla_rdata_o;
  logic                      dla_done_i;
  logic [BANK_W-1:0]         wbank_o;
  logic [BANK_W-1:0]         rbank_o;
  logic [BANK_W:0]           full_cnt_o;
  logic                      err_o;

  modport slave (
    input  top_start_i, pad_mode_i,
    input  isp_wen_i, isp_waddr_i, isp_wdata_i, isp_done_i,
    input  dla_ren_i, dla_raddr_i, dla_done_i,
    output isp_rdy_o, dla_rdy_o, dla_rdata_o,
    output wbank_o, rbank_o, full_cnt_o, err_o
  );

  modport master (
    output top_start_i, pad_mode_i,
    output isp_wen_i, isp_waddr_i, isp_wdata_i, isp_done_i,
    output dla_ren_i, dla_raddr_i, dla_done_i,
    input  isp_rdy_o, dla_rdy_o, dla_rdata_o,
    input  wbank_o, rbank_o, full_cnt_o, err_o
  );
endinterface

// File: rtl/ppp_mbank_buf.sv
// NUM_BANK-deep ISP-to-DLA ping-pong buffer: ISP fills one bank while the DLA drains
// an earlier one; reads widen CH_IN channels to CH_OUT with zero or channel-0 padding.
module ppp_mbank_buf #(
  parameter int NUM_BANK   = 2,
  parameter int PIX_NUM    = 32,
  parameter int CH_IN      = 3,
  parameter int CH_OUT     = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_DEPTH = 1024
) (
  input logic clk,
  input logic rst,
  ppp_mbank_buf_if.slave bus
);
  localparam int ISP_DATA_WIDTH = CH_IN * PIX_NUM * 8;
  localparam int DLA_DATA_WIDTH = CH_OUT * PIX_NUM * 8;
  localparam int CH_W           = PIX_NUM * 8;
  localparam int BW             = $clog2(NUM_BANK);
  localparam int IDX_W          = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DATA_DEPTH);

  typedef enum logic [1:0] {FREE, FILL, FULL, DRAIN} bank_state_t;

  bank_state_t state   [NUM_BANK];
  bank_state_t state_n [NUM_BANK];

  logic [BW-1:0] wbank, wbank_n, rbank, rbank_n;
  logic [BW:0]   full_cnt, full_cnt_n;
  logic          err, err_n;
  logic          isp_rdy, isp_rdy_n, dla_rdy, dla_rdy_n;
  logic          waddr_ok, raddr_ok, fill_done, drain_done, wr_acc, rd_acc;

  logic [ISP_DATA_WIDTH-1:0] mem [NUM_BANK][DATA_DEPTH];
  logic [ISP_DATA_WIDTH-1:0] rd_word;
  logic [DLA_DATA_WIDTH-1:0] packed_word, rdata;

  always_comb begin
    waddr_ok   = {1'b0, bus.isp_waddr_i} < DEPTH_LIM;
    raddr_ok   = {1'b0, bus.dla_raddr_i} < DEPTH_LIM;
    fill_done  = bus.isp_done_i && isp_rdy;
    drain_done = bus.dla_done_i && dla_rdy;
    wr_acc     = bus.isp_wen_i && isp_rdy && waddr_ok && !bus.top_start_i;
    rd_acc     = bus.dla_ren_i && dla_rdy && raddr_ok && !bus.top_start_i;
  end

  // Only wbank may leave FREE/FILL and only rbank may leave FULL/DRAIN, which keeps
  // FILL and DRAIN exclusive per bank; top_start overrides everything.
  always_comb begin
    for (int i = 0; i < NUM_BANK; i++) begin
      state_n[i] = state[i];
      unique case (state[i])
        FREE:  if (BW'(i) == wbank) state_n[i] = FILL;
        FILL:  if (BW'(i) == wbank && fill_done) state_n[i] = FULL;
        FULL:  if (BW'(i) == rbank) state_n[i] = DRAIN;
        DRAIN: if (BW'(i) == rbank && drain_done) state_n[i] = FREE;
      endcase
    end
    wbank_n    = wbank + BW'(fill_done);
    rbank_n    = rbank + BW'(drain_done);
    full_cnt_n = full_cnt + (BW + 1)'(fill_done) - (BW + 1)'(drain_done);
    err_n      = err
               | ((bus.isp_wen_i || bus.isp_done_i) && !isp_rdy)
               | ((bus.dla_ren_i || bus.dla_done_i) && !dla_rdy)
               | (bus.isp_wen_i && !waddr_ok)
               | (bus.dla_ren_i && !raddr_ok);
    if (bus.top_start_i) begin
      for (int i = 0; i < NUM_BANK; i++) state_n[i] = FREE;
      wbank_n    = '0;
      rbank_n    = '0;
      full_cnt_n = '0;
      err_n      = 1'b0;
    end
    isp_rdy_n = (state_n[wbank_n] == FILL);
    dla_rdy_n = (state_n[rbank_n] == DRAIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BANK; i++) state[i] <= FREE;
      wbank    <= '0;
      rbank    <= '0;
      full_cnt <= '0;
      err      <= 1'b0;
      isp_rdy  <= 1'b0;
      dla_rdy  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_BANK; i++) state[i] <= state_n[i];
      wbank    <= wbank_n;
      rbank    <= rbank_n;
      full_cnt <= full_cnt_n;
      err      <= err_n;
      isp_rdy  <= isp_rdy_n;
      dla_rdy  <= dla_rdy_n;
    end
  end

  // Bank RAM keeps its contents across rst and top_start.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wbank][bus.isp_waddr_i[IDX_W-1:0]] <= bus.isp_wdata_i;
  end

  assign rd_word = mem[rbank][bus.dla_raddr_i[IDX_W-1:0]];

  assign packed_word[ISP_DATA_WIDTH-1:0] = rd_word;
  for (genvar c = CH_IN; c < CH_OUT; c++) begin : g_pad
    assign packed_word[c*CH_W +: CH_W] = bus.pad_mode_i ? rd_word[CH_W-1:0] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rdata <= '0;
    else if (rd_acc) rdata <= packed_word;
  end

  assign bus.isp_rdy_o   = isp_rdy;
  assign bus.dla_rdy_o   = dla_rdy;
  assign bus.dla_rdata_o = rdata;
  assign bus.wbank_o     = wbank;
  assign bus.rbank_o     = rbank;
  assign bus.full_cnt_o  = full_cnt;
  assign bus.err_o       = err;
endmodule

// File: tb/tb_ppp_mbank_buf.sv
// Bench for ppp_mbank_buf: table vectors, directed corner sequences and random traffic,
// all checked against a bank-count/pointer model of the buffer.
module tb_ppp_mbank_buf;
  localparam int NB = 4;
  localparam int PIX = 4;
  localparam int CI = 3;
  localparam int CO = 4;
  localparam int AW = 7;
  localparam int DD = 64;
  localparam int CW = PIX * 8;
  localparam int IW = CI * CW;
  localparam int OW = CO * CW;
  localparam int BW = 2;

  typedef struct {
    logic start, pad, wen;
    logic [AW-1:0] waddr;
    logic [IW-1:0] wdata;
    logic done, ren;
    logic [AW-1:0] raddr;
    logic dla_done;
    logic isp, dla;
    logic [BW-1:0] wb, rb;
    logic [BW:0] cnt;
    logic err;
    logic chk_rd;
    logic [OW-1:0] rd;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nmis = 0;

  ppp_mbank_buf_if #(.NUM_BANK(NB), .PIX_NUM(PIX), .CH_IN(CI), .CH_OUT(CO), .ADDR_WIDTH(AW)) bus ();

  ppp_mbank_buf #(
    .NUM_BANK(NB), .PIX_NUM(PIX), .CH_IN(CI), .CH_OUT(CO), .ADDR_WIDTH(AW), .DATA_DEPTH(DD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Model: banks in FULL/DRAIN form a run starting at rb, so the write bank is free
  // exactly when fewer than NB banks are occupied.
  logic [IW-1:0] m_mem [NB][DD];
  bit            m_wr  [NB][DD];
  int            m_wb, m_rb, m_cnt;
  bit            m_fa, m_da, m_err, m_rd_valid;
  logic [OW-1:0] m_rd;

  function automatic logic [OW-1:0] packRead(input logic [IW-1:0] w, input logic p);
    logic [OW-1:0] r;
    r = '0;
    r[IW-1:0] = w;
    for (int c = CI; c < CO; c++) r[c*CW +: CW] = p ? w[CW-1:0] : '0;
    return r;
  endfunction

  task automatic modelReset();
    m_wb = 0; m_rb = 0; m_cnt = 0;
    m_fa = 0; m_da = 0; m_err = 0;
    m_rd = '0; m_rd_valid = 1;
  endtask

  task automatic modelStep(input vec_t v);
    bit ifire, dfire, nfa, nda;
    ifire = v.done && m_fa;
    dfire = v.dla_done && m_da;
    if (v.start) begin
      m_wb = 0; m_rb = 0; m_cnt = 0; m_fa = 0; m_da = 0; m_err = 0;
    end else begin
      m_err = m_err || ((v.wen || v.done) && !m_fa) || ((v.ren || v.dla_done) && !m_da)
              || (v.wen && int'(v.waddr) >= DD) || (v.ren && int'(v.raddr) >= DD);
      if (v.wen && m_fa && int'(v.waddr) < DD) begin
        m_mem[m_wb][v.waddr] = v.wdata;
        m_wr[m_wb][v.waddr]  = 1;
      end
      if (v.ren && m_da && int'(v.raddr) < DD) begin
        m_rd       = packRead(m_mem[m_rb][v.raddr], v.pad);
        m_rd_valid = m_wr[m_rb][v.raddr];
      end
      nfa   = !ifire && (m_fa || m_cnt < NB);
      nda   = !dfire && (m_da || m_cnt > 0);
      m_cnt = m_cnt + int'(ifire) - int'(dfire);
      m_wb  = (m_wb + int'(ifire)) % NB;
      m_rb  = (m_rb + int'(dfire)) % NB;
      m_fa  = nfa;
      m_da  = nda;
    end
  endtask

  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    cmp("isp_rdy", 128'(bus.isp_rdy_o), 128'(m_fa));
    cmp("dla_rdy", 128'(bus.dla_rdy_o), 128'(m_da));
    cmp("wbank", 128'(bus.wbank_o), 128'(m_wb));
    cmp("rbank", 128'(bus.rbank_o), 128'(m_rb));
    cmp("full_cnt", 128'(bus.full_cnt_o), 128'(m_cnt));
    cmp("err", 128'(bus.err_o), 128'(m_err));
    if (m_rd_valid) cmp("rdata", 128'(bus.dla_rdata_o), 128'(m_rd));
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.top_start_i = v.start;
    bus.pad_mode_i  = v.pad;
    bus.isp_wen_i   = v.wen;
    bus.isp_waddr_i = v.waddr;
    bus.isp_wdata_i = v.wdata;
    bus.isp_done_i  = v.done;
    bus.dla_ren_i   = v.ren;
    bus.dla_raddr_i = v.raddr;
    bus.dla_done_i  = v.dla_done;
    @(posedge clk);
    modelStep(v);
    #1;
    checkOutput();
  endtask

  function automatic vec_t stim(input logic s, input logic p, input logic we, input int wa,
                                input logic [7:0] wbyte, input logic dn, input logic re,
                                input int ra, input logic dd);
    vec_t v;
    v.start = s; v.pad = p; v.wen = we; v.waddr = AW'(wa); v.wdata = {12{wbyte}};
    v.done = dn; v.ren = re; v.raddr = AW'(ra); v.dla_done = dd;
    v.isp = 0; v.dla = 0; v.wb = '0; v.rb = '0; v.cnt = '0; v.err = 0;
    v.chk_rd = 0; v.rd = '0;
    return v;
  endfunction

  function automatic vec_t expv(input vec_t v, input logic i, input logic d, input int w,
                                input int r, input int c, input logic e);
    vec_t o;
    o = v;
    o.isp = i; o.dla = d; o.wb = BW'(w); o.rb = BW'(r); o.cnt = (BW + 1)'(c); o.err = e;
    return o;
  endfunction

  task automatic idleStep();
    applyStimulus(stim(0, 0, 0, 0, 8'h00, 0, 0, 0, 0));
  endtask

  task automatic waitIsp(input int bound);
    for (int k = 0; k < bound && !bus.isp_rdy_o; k++) idleStep();
    cmp("isp_rdy_wait", 128'(bus.isp_rdy_o), 128'(1));
  endtask

  task automatic waitDla(input int bound);
    for (int k = 0; k < bound && !bus.dla_rdy_o; k++) idleStep();
    cmp("dla_rdy_wait", 128'(bus.dla_rdy_o), 128'(1));
  endtask

  task automatic checkAllZero(input string tag);
    cmp({tag, "_isp_rdy"}, 128'(bus.isp_rdy_o), 128'(0));
    cmp({tag, "_dla_rdy"}, 128'(bus.dla_rdy_o), 128'(0));
    cmp({tag, "_wbank"}, 128'(bus.wbank_o), 128'(0));
    cmp({tag, "_rbank"}, 128'(bus.rbank_o), 128'(0));
    cmp({tag, "_full_cnt"}, 128'(bus.full_cnt_o), 128'(0));
    cmp({tag, "_err"}, 128'(bus.err_o), 128'(0));
    cmp({tag, "_rdata"}, 128'(bus.dla_rdata_o), 128'(0));
  endtask

  vec_t tab [12];

  initial begin
    logic [7:0] b;
    vec_t v;
    b = 8'h55;
    tab[0]  = expv(stim(0, 0, 0, 0, 8'h00, 0, 0, 0, 0), 1, 0, 0, 0, 0, 0);
    tab[1]  = expv(stim(0, 0, 1, 5, b, 0, 0, 0, 0), 1, 0, 0, 0, 0, 0);
    tab[2]  = expv(stim(0, 0, 0, 0, 8'h00, 1, 0, 0, 0), 0, 0, 1, 0, 1, 0);
    tab[3]  = expv(stim(0, 0, 0, 0, 8'h00, 0, 0, 0, 0), 1, 1, 1, 0, 1, 0);
    tab[4]  = expv(stim(0, 0, 0, 0, 8'h00, 0, 1, 5, 0), 1, 1, 1, 0, 1, 0);
    tab[4].chk_rd = 1; tab[4].rd = {32'h0, {12{b}}};
    tab[5]  = expv(stim(0, 1, 0, 0, 8'h00, 0, 1, 5, 0), 1, 1, 1, 0, 1, 0);
    tab[5].chk_rd = 1; tab[5].rd = {16{b}};
    tab[6]  = expv(stim(0, 0, 0, 0, 8'h00, 1, 0, 0, 1), 0, 0, 2, 1, 1, 0);
    tab[7]  = expv(stim(0, 0, 0, 0, 8'h00, 0, 0, 0, 0), 1, 1, 2, 1, 1, 0);
    tab[8]  = expv(stim(0, 0, 1, 64, 8'hAA, 0, 0, 0, 0), 1, 1, 2, 1, 1, 1);
    tab[9]  = expv(stim(0, 0, 0, 0, 8'h00, 0, 0, 0, 0), 1, 1, 2, 1, 1, 1);
    tab[10] = expv(stim(1, 0, 0, 0, 8'h00, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0);
    tab[11] = expv(stim(0, 0, 0, 0, 8'h00, 0, 0, 0, 0), 1, 0, 0, 0, 0, 0);

    v = stim(0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    bus.top_start_i = 0; bus.pad_mode_i = 0; bus.isp_wen_i = 0; bus.isp_waddr_i = '0;
    bus.isp_wdata_i = '0; bus.isp_done_i = 0; bus.dla_ren_i = 0; bus.dla_raddr_i = '0;
    bus.dla_done_i = 0;
    modelReset();
    #1;
    checkAllZero("reset");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] table vectors");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(tab[i]);
      cmp($sformatf("tab%0d_isp_rdy", i), 128'(bus.isp_rdy_o), 128'(tab[i].isp));
      cmp($sformatf("tab%0d_dla_rdy", i), 128'(bus.dla_rdy_o), 128'(tab[i].dla));
      cmp($sformatf("tab%0d_wbank", i), 128'(bus.wbank_o), 128'(tab[i].wb));
      cmp($sformatf("tab%0d_rbank", i), 128'(bus.rbank_o), 128'(tab[i].rb));
      cmp($sformatf("tab%0d_full_cnt", i), 128'(bus.full_cnt_o), 128'(tab[i].cnt));
      cmp($sformatf("tab%0d_err", i), 128'(bus.err_o), 128'(tab[i].err));
      if (tab[i].chk_rd) cmp($sformatf("tab%0d_rdata", i), 128'(bus.dla_rdata_o), 128'(tab[i].rd));
    end

    $display("[TB] fill/drain one bank with zero and replicate padding");
    for (int a = 0; a < 32; a++) applyStimulus(stim(0, 0, 1, a, 8'(a), 0, 0, 0, 0));
    applyStimulus(stim(0, 0, 0, 0, 8'h00, 1, 0, 0, 0));
    cmp("fill_cnt", 128'(bus.full_cnt_o), 128'(1));
    waitDla(4);
    for (int a = 0; a < 32; a++) begin
      applyStimulus(stim(0, 0, 0, 0, 8'h00, 0, 1, a, 0));
      cmp($sformatf("rd_zero_%0d", a), 128'(bus.dla_rdata_o), 128'({32'h0, {12{8'(a)}}}));
    end
    for (int a = 0; a < 32; a += 7) begin
      applyStimulus(stim(0, 1, 0, 0, 8'h00, 0, 1, a, 0));
      cmp($sformatf("rd_rep_%0d", a), 128'(bus.dla_rdata_o), 128'({16{8'(a)}}));
    end
    cmp("flow_err", 128'(bus.err_o), 128'(0));
    applyStimulus(stim(0, 0, 0, 0, 8'h00, 0, 0, 0, 1));
    cmp("drain_cnt", 128'(bus.full_cnt_o), 128'(0));

    $display("[TB] all banks full stalls the ISP");
    applyStimulus(stim(1, 0, 0, 0, 8'h00, 0, 0, 0, 0));
    for (int k = 0; k < NB; k++) begin
      waitIsp(4);
      applyStimulus(stim(0, 0, 1, 1, 8'(8'h10 + k), 1, 0, 0, 0));
    end
    idleStep();
    idleStep();
    cmp("full4_cnt", 128'(bus.full_cnt_o), 128'(4));
    cmp("full4_isp_rdy", 128'(bus.isp_rdy_o), 128'(0));
    waitDla(4);
    applyStimulus(stim(0, 0, 0, 0, 8'h00, 0, 0, 0, 1));
    for (int k = 0; k < 2 && !bus.isp_rdy_o; k++) idleStep();
    cmp("free1_isp_rdy", 128'(bus.isp_rdy_o), 128'(1));
    cmp("free1_wbank", 128'(bus.wbank_o), 128'(0));

    $display("[TB] simultaneous isp_done and dla_done");
    waitDla(4);
    applyStimulus(stim(0, 0, 0, 0, 8'h00, 1, 0, 0, 1));
    cmp("both_cnt", 128'(bus.full_cnt_o), 128'(3));
    cmp("both_wbank", 128'(bus.wbank_o), 128'(1));
    cmp("both_rbank", 128'(bus.rbank_o), 128'(2));

    $display("[TB] protocol errors and soft clear");
    applyStimulus(stim(0, 0, 1, 1, 8'hEE, 0, 0, 0, 0));
    cmp("wen_nordy_err", 128'(bus.err_o), 128'(1));
    waitDla(4);
    applyStimulus(stim(0, 0, 0, 0, 8'h00, 0, 1, DD, 0));
    idleStep();
    cmp("sticky_err", 128'(bus.err_o), 128'(1));
    applyStimulus(stim(0, 0, 0, 0, 8'h00, 0, 1, 1, 0));
    cmp("rd_unchanged", 128'(bus.dla_rdata_o), 128'({32'h0, {12{8'h12}}}));
    applyStimulus(stim(1, 0, 0, 0, 8'h00, 0, 0, 0, 0));
    cmp("clr_err", 128'(bus.err_o), 128'(0));
    cmp("clr_wbank", 128'(bus.wbank_o), 128'(0));
    cmp("clr_rbank", 128'(bus.rbank_o), 128'(0));
    cmp("clr_cnt", 128'(bus.full_cnt_o), 128'(0));

    $display("[TB] asynchronous reset mid-fill");
    waitIsp(4);
    applyStimulus(stim(0, 0, 1, 2, 8'h77, 0, 0, 0, 0));
    #3;
    rst = 1'b1;
    #1;
    checkAllZero("async");
    modelReset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2 && !bus.isp_rdy_o; k++) idleStep();
    cmp("rst_isp_rdy", 128'(bus.isp_rdy_o), 128'(1));
    cmp("rst_wbank", 128'(bus.wbank_o), 128'(0));

    $display("[TB] random traffic");
    for (int n = 0; n < 4000; n++) begin
      v = stim(0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
      v.start    = ($urandom_range(0, 299) == 0);
      v.pad      = 1'($urandom_range(0, 1));
      v.wen      = ($urandom_range(0, 1) == 1) && (bus.isp_rdy_o || $urandom_range(0, 29) == 0);
      v.waddr    = ($urandom_range(0, 29) == 0) ? AW'($urandom_range(DD, 127)) : AW'($urandom_range(0, DD - 1));
      v.wdata    = {$urandom, $urandom, $urandom};
      v.done     = ($urandom_range(0, 19) == 0) && (bus.isp_rdy_o || $urandom_range(0, 29) == 0);
      v.ren      = ($urandom_range(0, 1) == 1) && (bus.dla_rdy_o || $urandom_range(0, 29) == 0);
      v.raddr    = ($urandom_range(0, 29) == 0) ? AW'($urandom_range(DD, 127)) : AW'($urandom_range(0, DD - 1));
      v.dla_done = ($urandom_range(0, 17) == 0) && (bus.dla_rdy_o || $urandom_range(0, 29) == 0);
      applyStimulus(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/ppp_mbank_buf.md
Name: ppp_mbank_buf

Overview:
Next-generation ISP-to-DLA pre-processing ping-pong buffer, generalised to NUM_BANK banks with configurable input/output channel counts. The ISP fills one bank at a time while the DLA drains a previously filled bank. On read, the block widens CH_IN channels to CH_OUT channels using zero or replicate padding. It sits between the ISP write port and the DLA read port inside the ppp top level.

Parameters:
NUM_BANK, 2, number of banks; power of two, 2..8
PIX_NUM, 32, pixels per channel per word
CH_IN, 3, channels per ISP word
CH_OUT, 4, channels per DLA word; must be >= CH_IN
ADDR_WIDTH, 10, word address width inside one bank
DATA_DEPTH, 1024, words per bank; must be <= 2**ADDR_WIDTH
ISP_DATA_WIDTH, CH_IN*PIX_NUM*8, ISP word width (derived)
DLA_DATA_WIDTH, CH_OUT*PIX_NUM*8, DLA word width (derived)

Ports:
clk  in  1  clock; all logic rising-edge
rst  in  1  asynchronous, active-high reset
top_start_i  in  1  synchronous soft clear: all banks FREE, pointers to 0, err cleared
pad_mode_i  in  1  0: pad channels are zero; 1: pad channels copy channel 0
isp_rdy_o  out  1  current ISP bank is in FILL
isp_wen_i  in  1  write enable
isp_waddr_i  in  ADDR_WIDTH  write word address
isp_wdata_i  in  ISP_DATA_WIDTH  write data, channel-major, ch0 in LSBs
isp_done_i  in  1  one-cycle pulse: current fill bank complete
dla_rdy_o  out  1  current DLA bank is in DRAIN
dla_ren_i  in  1  read enable
dla_raddr_i  in  ADDR_WIDTH  read word address
dla_rdata_o  out  DLA_DATA_WIDTH  read data, valid 1 cycle after dla_ren_i
dla_done_i  in  1  one-cycle pulse: current drain bank consumed
wbank_o  out  log2(NUM_BANK)  current ISP bank index
rbank_o  out  log2(NUM_BANK)  current DLA bank index
full_cnt_o  out  log2(NUM_BANK)+1  number of banks in FULL or DRAIN
err_o  out  1  sticky protocol error

Behaviour:
- Reset: all banks FREE. wbank_o=0, rbank_o=0, full_cnt_o=0, err_o=0, isp_rdy_o=0, dla_rdy_o=0, dla_rdata_o=0. RAM contents are not reset.
- Per-bank FSM: FREE -> FILL -> FULL -> DRAIN -> FREE.
  - FREE -> FILL: the bank is wbank and is FREE; takes 1 cycle. isp_rdy_o rises the cycle after the bank becomes FREE.
  - FILL -> FULL: isp_done_i while isp_rdy_o. wbank advances modulo NUM_BANK on the same edge.
  - FULL -> DRAIN: the bank is rbank and is FULL; takes 1 cycle.
  - DRAIN -> FREE: dla_done_i while dla_rdy_o. rbank advances modulo NUM_BANK on the same edge.
- isp_rdy_o = (state[wbank]==FILL). dla_rdy_o = (state[rbank]==DRAIN). Both are registered outputs.
- Write: accepted when isp_wen_i && isp_rdy_o && isp_waddr_i < DATA_DEPTH; the word is written to bank wbank.
- Read: the address is sampled when dla_ren_i && dla_rdy_o. dla_rdata_o updates on the next edge and holds until the next accepted read.
- Read packing:
  - dla_rdata_o channels 0..CH_IN-1 are the stored channels.
  - Channels CH_IN..CH_OUT-1 are 0 (pad_mode_i=0) or a copy of channel 0 (pad_mode_i=1).
  - pad_mode_i is sampled with the read address.
- full_cnt_o: +1 on FILL->FULL, -1 on DRAIN->FREE, unchanged when both occur in the same cycle.
- err_o sets on any of:
  - isp_wen_i or isp_done_i while !isp_rdy_o
  - dla_ren_i or dla_done_i while !dla_rdy_o
  - an out-of-range address with its enable asserted
- Offending requests are dropped. err_o is cleared only by rst or top_start_i.
- All banks full: the ISP stalls (isp_rdy_o=0) until the DLA frees wbank. All banks free: dla_rdy_o=0.
- isp_done_i and dla_done_i in the same cycle act on different banks; both take effect.
- top_start_i dominates all same-cycle events. It aborts any fill or drain in progress and does not clear RAM.
- Read-during-write cannot hit the same bank, because FILL and DRAIN are exclusive per bank.

Test Plan:
1. NUM_BANK=2, CH_IN=3, CH_OUT=4, pad_mode=0. ISP writes bank 0 addr a with bytes = a[7:0] for a=0..31, then isp_done_i. DLA reads addr 0..31 -> dla_rdata_o = {32'h0 bytes, 96 bytes of a}. err_o=0. full_cnt_o goes 1 then 0 after dla_done_i.
2. pad_mode=1, same data -> top 32 bytes of each read word equal channel 0 bytes (value a).
3. NUM_BANK=4. ISP fills 4 banks with no DLA activity -> full_cnt_o=4, isp_rdy_o=0. One dla_done_i -> isp_rdy_o=1 within 2 cycles, wbank_o=0.
4. isp_done_i and dla_done_i in the same cycle with 1 bank full, 1 filling -> full_cnt_o unchanged, wbank and rbank both advance.
5. isp_wen_i while isp_rdy_o=0, and dla_raddr_i=DATA_DEPTH -> err_o=1, sticky. Memory is unchanged (read back the original data). top_start_i -> err_o=0, all pointers 0.
6. Assert rst mid-fill -> all outputs at reset values immediately (async). After release, isp_rdy_o=1 on bank 0 within 2 cycles.
